// File: rtl/stream_mux_rr.sv
// N-channel registered stream mux with fixed-select or round-robin arbitration.
// Optional STREAM_MUX_CNT_EN adds a 16-bit xfer_cnt output counting completed transfers.
module stream_mux_rr #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_ch,
    output logic                     out_valid,
    input  logic                     out_ready
`ifdef STREAM_MUX_CNT_EN
    ,
    output logic [15:0]              xfer_cnt
`endif
);

    localparam int unsigned NCH = NUM_CH;

    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0]  out_ch_q, out_ch_d;
    logic              out_valid_q, out_valid_d;
    logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;

    logic              load;
    logic              grant;
    logic [SEL_W-1:0]  grant_idx;
    logic [SEL_W-1:0]  cand;
    logic [DATA_W-1:0] grant_data;

    assign load = !out_valid_q || out_ready;

    // Arbitration: fixed select, or first valid channel scanning upward from rr_ptr.
    always_comb begin
        grant     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if (!mode) begin
            if (32'(sel) < NCH) begin
                grant     = in_valid[sel];
                grant_idx = sel;
            end
        end else begin
            for (int unsigned k = 0; k < NCH; k++) begin
                cand = SEL_W'((32'(rr_ptr_q) + k) % NCH);
                if (!grant && in_valid[cand]) begin
                    grant     = 1'b1;
                    grant_idx = cand;
                end
            end
        end
    end

    always_comb begin
        grant_data = '0;
        in_ready   = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (grant_idx == SEL_W'(i)) begin
                grant_data  = in_data[i*DATA_W +: DATA_W];
                in_ready[i] = rst_n && load && grant;
            end
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        if (load) begin
            if (grant) begin
                out_data_d  = grant_data;
                out_ch_d    = grant_idx;
                out_valid_d = 1'b1;
                if (mode) begin
                    rr_ptr_d = (grant_idx == SEL_W'(NCH - 1)) ? '0 : SEL_W'(grant_idx + 1'b1);
                end
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

`ifdef STREAM_MUX_CNT_EN
    logic [15:0] xfer_cnt_q, xfer_cnt_d;

    always_comb begin
        xfer_cnt_d = xfer_cnt_q;
        if (out_valid_q && out_ready) begin
            xfer_cnt_d = xfer_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt_q <= '0;
        end else begin
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    assign xfer_cnt = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed testbench for stream_mux_rr: a 4-channel and a 3-channel instance.
// Counter checks compile in only when STREAM_MUX_CNT_EN is defined.
module tb_stream_mux_rr;

    logic        clk;
    logic        rst_n;

    logic        mode;
    logic [1:0]  sel;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_valid;
    logic        out_ready;

    logic        m3;
    logic [1:0]  sel3;
    logic [23:0] d3;
    logic [2:0]  v3;
    logic [2:0]  rdy3;
    logic [7:0]  od3;
    logic [1:0]  och3;
    logic        ov3;
    logic        ordy3;

`ifdef STREAM_MUX_CNT_EN
    logic [15:0] xfer_cnt;
    logic [15:0] xfer_cnt3;
`endif

    int checks;
    int failures;

    stream_mux_rr #(.NUM_CH(4), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
        .out_ready(out_ready)
`ifdef STREAM_MUX_CNT_EN
        , .xfer_cnt(xfer_cnt)
`endif
    );

    stream_mux_rr #(.NUM_CH(3), .DATA_W(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .mode(m3), .sel(sel3),
        .in_data(d3), .in_valid(v3), .in_ready(rdy3),
        .out_data(od3), .out_ch(och3), .out_valid(ov3),
        .out_ready(ordy3)
`ifdef STREAM_MUX_CNT_EN
        , .xfer_cnt(xfer_cnt3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int unsigned rr_ch[6]   = '{0, 1, 3, 0, 1, 3};
    logic [7:0]  rr_data[6] = '{8'h11, 8'h22, 8'h44, 8'h11, 8'h22, 8'h44};

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        mode      = 1'b0;
        sel       = '0;
        in_data   = '0;
        in_valid  = '0;
        out_ready = 1'b0;
        m3        = 1'b0;
        sel3      = '0;
        d3        = '0;
        v3        = '0;
        ordy3     = 1'b0;

        repeat (2) step();
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_ch", out_ch, 0);
        check("rst_ready", in_ready, 0);
        rst_n = 1'b1;
        step();

        // Fixed select of channel 2
        mode = 1'b0; sel = 2'd2; in_valid = 4'hF; in_data = 32'h44A52211; out_ready = 1'b1;
        #1;
        check("fix_ready", in_ready, 4'b0100);
        step();
        check("fix_valid", out_valid, 1);
        check("fix_data", out_data, 8'hA5);
        check("fix_ch", out_ch, 2);
        in_data = 32'h445A2211;
        #1;
        check("fix_ready2", in_ready, 4'b0100);
        step();
        check("fix_data2", out_data, 8'h5A);
        check("fix_valid2", out_valid, 1);

        // Round-robin over channels 0,1,3
        in_data = 32'h44332211;
        mode = 1'b1; in_valid = 4'b1011;
        for (int i = 0; i < 6; i++) begin
            step();
            check("rr_ch", out_ch, rr_ch[i]);
            check("rr_data", out_data, rr_data[i]);
            check("rr_valid", out_valid, 1);
        end

        // Backpressure holding ch3, rr_ptr at 0
        out_ready = 1'b0;
        #1;
        check("bp_ready0", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_ch", out_ch, 3);
            check("bp_data", out_data, 8'h44);
            check("bp_valid", out_valid, 1);
            check("bp_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 4'b0001);
        step();
        check("bp_next_ch", out_ch, 0);
        check("bp_next_data", out_data, 8'h11);

        // Mode switch keeps rr_ptr (now 1)
        mode = 1'b0; sel = 2'd1;
        step();
        check("mc_fix_ch", out_ch, 1);
        check("mc_fix_data", out_data, 8'h22);
        mode = 1'b1;
        #1;
        check("mc_rr_ready", in_ready, 4'b0010);
        step();
        check("mc_rr_ch", out_ch, 1);

        // No valid input: drain, registers hold
        in_valid = '0;
        step();
        check("idle_valid", out_valid, 0);
        check("idle_data", out_data, 8'h22);
        check("idle_ch", out_ch, 1);
        check("idle_ready", in_ready, 0);

        // Mid-stream asynchronous reset
        in_valid = 4'b1011;
        step();
        check("pre_rst_ch", out_ch, 3);
        check("pre_rst_valid", out_valid, 1);
        out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_ch", out_ch, 0);
        check("arst_data", out_data, 0);
        check("arst_ready", in_ready, 0);
        step();
        rst_n = 1'b1; out_ready = 1'b1;
        #1;
        check("post_rst_ready", in_ready, 4'b0001);
        step();
        check("post_rst_ch", out_ch, 0);
        check("post_rst_valid", out_valid, 1);

        // 3-channel instance: out-of-range select
        m3 = 1'b0; sel3 = 2'd0; v3 = 3'b111; d3 = 24'hC3B2A1; ordy3 = 1'b1;
        step();
        check("n3_valid", ov3, 1);
        check("n3_ch", och3, 0);
        check("n3_data", od3, 8'hA1);
        ordy3 = 1'b0; sel3 = 2'd3;
        #1;
        check("n3_bad_ready0", rdy3, 0);
        step();
        check("n3_pending_valid", ov3, 1);
        check("n3_pending_data", od3, 8'hA1);
        ordy3 = 1'b1;
        #1;
        check("n3_bad_ready1", rdy3, 0);
        step();
        check("n3_drained_valid", ov3, 0);
        check("n3_drained_ready", rdy3, 0);

`ifdef STREAM_MUX_CNT_EN
        rst_n = 1'b0; in_valid = '0; out_ready = 1'b0;
        step();
        check("cnt_rst", xfer_cnt, 0);
        rst_n = 1'b1; mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
        step();
        repeat (65535) step();
        check("cnt_ffff", xfer_cnt, 16'hFFFF);
        step();
        check("cnt_wrap", xfer_cnt, 16'h0000);
        step();
        check("cnt_one", xfer_cnt, 16'h0001);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel registered stream multiplexer with valid/ready handshakes. It succeeds the fixed 4:1 single-bit mux. It merges NUM_CH input streams of DATA_W bits into one output stream using either an externally driven select (fixed mode) or round-robin arbitration. It has a single output register stage and sits between parallel producers and a single shared consumer, for example a bus or FIFO write port.

## Interface
- NUM_CH, default 4: number of input channels, minimum 2.
- DATA_W, default 8: data width per channel, minimum 1.
- SEL_W, default $clog2(NUM_CH): select and channel-ID width. It is derived and must not be overridden.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  1  arbitration mode: 0 = fixed select, 1 = round-robin.
- sel  in  SEL_W  channel select, used only in mode 0.
- in_data  in  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- in_valid  in  NUM_CH  per-channel valid.
- in_ready  out  NUM_CH  per-channel ready.
- out_data  out  DATA_W  registered output data.
- out_ch  out  SEL_W  index of the channel that out_data came from.
- out_valid  out  1  output valid.
- out_ready  in  1  consumer ready.
- xfer_cnt  out  16  count of completed output transfers. Present only with STREAM_MUX_CNT_EN.

## Operation
- load = !out_valid || out_ready. The output register may accept a new word this cycle.
- Mode 0 arbitration:
  - Candidate is sel.
  - Grant is issued if sel < NUM_CH and in_valid[sel]=1.
  - sel >= NUM_CH gives no grant.
- Mode 1 arbitration:
  - Scan indices rr_ptr, rr_ptr+1, … modulo NUM_CH.
  - Grant goes to the first index with in_valid set.
  - With no valid channel there is no grant.
- in_ready[i] = load && grant && (grant_idx == i). The outputs are combinational and one-hot or zero.
- Sources must not make in_valid depend on in_ready.
- Register update when load=1:
  - With a grant: out_data <= selected data, out_ch <= grant_idx, out_valid <= 1.
  - Without a grant: out_valid <= 0. out_data and out_ch hold their values.
- Register update when load=0: all output registers hold.
- Round-robin pointer update:
  - rr_ptr updates only on a granted transfer in mode 1.
  - rr_ptr <= grant_idx+1, wrapping to 0 when grant_idx = NUM_CH-1.
  - In mode 0, rr_ptr holds its value.
- A mode change is used starting with the next arbitration cycle. rr_ptr is not reset by a mode change.
- Input data of a channel that is not granted is ignored. No word is ever duplicated or dropped.

## Timing
- Reset values: out_valid=0, out_data=0, out_ch=0, rr_ptr=0, xfer_cnt=0.
- Reset is asynchronous on assert and released synchronously by the clock edge after rst_n rises.
- Reset in mid-operation discards the word in the register. in_ready is 0 while rst_n=0.
- Latency: an input handshake at edge k gives out_valid=1 after edge k.
- Throughput: one word per cycle while out_ready=1.
- Backpressure:
  - With out_valid=1 and out_ready=0, all in_ready are 0 and out_data and out_ch are stable.
  - If out_ready=1 in the same cycle as a new grant, the old word is consumed and the new word is loaded at the same edge.
- Sel and mode are sampled only in cycles where load=1.

## Configuration
- STREAM_MUX_CNT_EN:
  - When defined, the xfer_cnt port and a 16-bit counter are present.
  - The counter increments on each cycle with out_valid && out_ready.
  - It wraps from 0xFFFF to 0x0000 and is cleared by reset.
- When the macro is not defined, the port and counter do not exist. The datapath behaviour is identical in both cases.

## Test plan
- Reset: drive rst_n=0 in mid-stream with out_valid=1. Required: out_valid=0, out_ch=0, in_ready=0 immediately. After release, the first grant in mode 1 goes to ch0.
- Fixed mode: NUM_CH=4, mode=0, sel=2, all in_valid=1, in_data ch2=0xA5, out_ready=1. Required: in_ready=4'b0100, then out_data=0xA5 and out_ch=2 the next cycle, at one word per cycle.
- Round-robin: mode=1 with in_valid=4'b1011 held and out_ready=1. Required grant order 0,1,3,0,1,3 with no gaps in out_valid.
- Backpressure: mode=1, out_ready=0 for 3 cycles after a load. Required: out_data and out_ch are stable, in_ready=0, and rr_ptr does not advance. After out_ready=1, the next channel in order is loaded at the same edge.
- Invalid select: NUM_CH=3, mode=0, sel=3, in_valid=3'b111. Required: no in_ready, and out_valid drops to 0 after the pending word drains.
- Counter (STREAM_MUX_CNT_EN): preload the counter by running 65535 transfers, then do 2 more. Required xfer_cnt sequence 0xFFFF, 0x0000, 0x0001. The build without the macro compiles without the xfer_cnt port.
